// File: rtl/occ_pkg.sv
// Shared types and helpers for the multi-channel occupancy tracker.
package occ_pkg;

  // Counter width needed to hold every value in 0..depth.
  function automatic int occ_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Registered per-channel status bits.
  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic ovf;
    logic udf;
  } occ_status_t;

endpackage

// File: rtl/occ_chan.sv
// One occupancy channel: saturating counter, peak watermark, flags and
// sticky over/underflow errors. Everything is registered from the next count.
module occ_chan
  import occ_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter int CNT_W    = occ_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             clr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] peak,
  output occ_status_t      status
);

  localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] peak_r;
  occ_status_t      status_r;

  logic [CNT_W-1:0] next_cnt_s;
  logic [CNT_W-1:0] next_peak_s;
  occ_status_t      next_status_s;
  logic             ovf_set_s;
  logic             udf_set_s;

  // Next count and error events; clear dominates, push+pop together is a no-op.
  always_comb begin
    next_cnt_s = count_r;
    ovf_set_s  = 1'b0;
    udf_set_s  = 1'b0;
    if (clr) begin
      next_cnt_s = ZERO_C;
    end else begin
      case ({up, down})
        2'b10: begin
          if (count_r < DEPTH_C) begin
            next_cnt_s = count_r + ONE_C;
          end else begin
            ovf_set_s = 1'b1;
          end
        end
        2'b01: begin
          if (count_r > ZERO_C) begin
            next_cnt_s = count_r - ONE_C;
          end else begin
            udf_set_s = 1'b1;
          end
        end
        default: begin
          next_cnt_s = count_r;
        end
      endcase
    end
  end

  // Next peak, flags and sticky errors derived from the next count.
  always_comb begin
    next_peak_s   = peak_r;
    next_status_s = status_r;
    if (clr) begin
      next_peak_s       = ZERO_C;
      next_status_s.ovf = 1'b0;
      next_status_s.udf = 1'b0;
    end else begin
      if (next_cnt_s > peak_r) begin
        next_peak_s = next_cnt_s;
      end else begin
        next_peak_s = peak_r;
      end
      // A fresh error in the same cycle as err_clr keeps the bit set.
      next_status_s.ovf = ovf_set_s | (status_r.ovf & ~err_clr);
      next_status_s.udf = udf_set_s | (status_r.udf & ~err_clr);
    end
    next_status_s.full   = (next_cnt_s == DEPTH_C);
    next_status_s.empty  = (next_cnt_s == ZERO_C);
    next_status_s.afull  = (next_cnt_s >= AF_C);
    next_status_s.aempty = (next_cnt_s <= AE_C);
  end

  // State registers; reset leaves the channel empty with no errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r         <= ZERO_C;
      peak_r          <= ZERO_C;
      status_r.full   <= 1'b0;
      status_r.empty  <= 1'b1;
      status_r.afull  <= 1'b0;
      status_r.aempty <= 1'b1;
      status_r.ovf    <= 1'b0;
      status_r.udf    <= 1'b0;
    end else begin
      count_r  <= next_cnt_s;
      peak_r   <= next_peak_s;
      status_r <= next_status_s;
    end
  end

  assign count  = count_r;
  assign peak   = peak_r;
  assign status = status_r;

endmodule

// File: rtl/occ_param_check.sv
// Elaboration-time range checks for the occupancy tracker parameters.
module occ_param_check #(
  parameter int NCH      = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) ();

  if (NCH < 1) begin : g_bad_nch
    $error("occ_tracker: NCH must be at least 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("occ_tracker: DEPTH must be at least 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("occ_tracker: AF_LEVEL must lie in 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL >= DEPTH)) begin : g_bad_ae
    $error("occ_tracker: AE_LEVEL must lie in 0..DEPTH-1");
  end

endmodule

// File: rtl/occ_tracker.sv
// Multi-channel occupancy tracker: NCH independent occ_chan instances with
// packed count/peak outputs, per-channel flags and a global any_full.
module occ_tracker
  import occ_pkg::*;
#(
  parameter int  NCH      = 4,
  parameter int  DEPTH    = 8,
  parameter int  AF_LEVEL = DEPTH - 2,
  parameter int  AE_LEVEL = 2,
  localparam int CNT_W    = occ_cnt_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       up,
  input  logic [NCH-1:0]       down,
  input  logic [NCH-1:0]       clr,
  input  logic [NCH-1:0]       err_clr,
  output logic [NCH*CNT_W-1:0] count,
  output logic [NCH*CNT_W-1:0] peak,
  output logic [NCH-1:0]       full,
  output logic [NCH-1:0]       empty,
  output logic [NCH-1:0]       afull,
  output logic [NCH-1:0]       aempty,
  output logic [NCH-1:0]       ovf,
  output logic [NCH-1:0]       udf,
  output logic                 any_full
);

  occ_param_check #(
    .NCH      (NCH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_param_check ();

  occ_status_t status_s [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    occ_chan #(
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL),
      .AE_LEVEL (AE_LEVEL),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .up      (up[i]),
      .down    (down[i]),
      .clr     (clr[i]),
      .err_clr (err_clr[i]),
      .count   (count[i*CNT_W +: CNT_W]),
      .peak    (peak[i*CNT_W +: CNT_W]),
      .status  (status_s[i])
    );

    assign full[i]   = status_s[i].full;
    assign empty[i]  = status_s[i].empty;
    assign afull[i]  = status_s[i].afull;
    assign aempty[i] = status_s[i].aempty;
    assign ovf[i]    = status_s[i].ovf;
    assign udf[i]    = status_s[i].udf;
  end

  // Registered full bits OR-ed straight through, adding no latency.
  assign any_full = |full;

endmodule

// File: tb/tb_occ_tracker.sv
// Scoreboard bench for occ_tracker: the driver pushes expected per-channel
// state for each cycle, the monitor pops and compares after each clock edge.
module tb_occ_tracker;

  localparam int NCH   = 4;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int AEL   = 2;
  localparam int CW    = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NCH-1:0]      up = '0, down = '0, clr = '0, err_clr = '0;
  logic [NCH*CW-1:0]   count, peak;
  logic [NCH-1:0]      full, empty, afull, aempty, ovf, udf;
  logic                any_full;

  occ_tracker #(.NCH(NCH), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .clr(clr), .err_clr(err_clr),
    .count(count), .peak(peak), .full(full), .empty(empty), .afull(afull),
    .aempty(aempty), .ovf(ovf), .udf(udf), .any_full(any_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          ch;
    int          cnt;
    int          pk;
    logic [5:0]  st;    // {full, empty, afull, aempty, ovf, udf}
    int          anyf;  // -1: not checked
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cycnt  = 0;
  int   tgt    = 0;

  // reference model for the random phase
  int   m_cnt [NCH];
  int   m_pk  [NCH];
  logic m_ovf [NCH];
  logic m_udf [NCH];

  // Monitor: after each rising edge, check every entry due for this cycle.
  exp_t       e;
  logic [5:0] gs;
  int         gc, gp;
  always @(posedge clk) begin
    cycnt = cycnt + 1;
    #1;
    while (q.size() > 0 && q[0].cyc <= cycnt) begin
      e  = q.pop_front();
      gc = int'(count[e.ch*CW +: CW]);
      gp = int'(peak[e.ch*CW +: CW]);
      gs = {full[e.ch], empty[e.ch], afull[e.ch], aempty[e.ch], ovf[e.ch], udf[e.ch]};
      n_chk = n_chk + 1;
      if (gc != e.cnt || gp != e.pk || gs != e.st ||
          (e.anyf >= 0 && int'(any_full) != e.anyf)) begin
        n_fail = n_fail + 1;
        $display("FAIL %s cyc=%0d ch=%0d: got cnt=%0d pk=%0d st=%b any=%0d, want cnt=%0d pk=%0d st=%b any=%0d",
                 e.nm, cycnt, e.ch, gc, gp, gs, any_full, e.cnt, e.pk, e.st, e.anyf);
      end
    end
  end

  task automatic step(input logic [3:0] u, input logic [3:0] d,
                      input logic [3:0] c, input logic [3:0] ec);
    @(negedge clk);
    up = u; down = d; clr = c; err_clr = ec;
    tgt = cycnt + 1;
  endtask

  task automatic expect_ch(input int ch, input int cnt, input int pk,
                           input logic fl, input logic em, input logic af,
                           input logic ae, input logic ov, input logic ud,
                           input int anyf, input string nm);
    exp_t x;
    x.cyc = tgt; x.ch = ch; x.cnt = cnt; x.pk = pk;
    x.st = {fl, em, af, ae, ov, ud}; x.anyf = anyf; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic chk_reset(input string nm);
    n_chk = n_chk + 1;
    if (count != '0 || peak != '0) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_cnt: got count=%h peak=%h, want 0", nm, count, peak);
    end
    n_chk = n_chk + 1;
    if (full != 4'h0 || empty != 4'hF || afull != 4'h0 || aempty != 4'hF || any_full != 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_flags: got full=%b empty=%b afull=%b aempty=%b any=%b, want 0000 1111 0000 1111 0",
               nm, full, empty, afull, aempty, any_full);
    end
    n_chk = n_chk + 1;
    if (ovf != 4'h0 || udf != 4'h0) begin
      n_fail = n_fail + 1;
      $display("FAIL %s_err: got ovf=%b udf=%b, want 0", nm, ovf, udf);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    logic [3:0] ru, rd, rc, re;
    int anyv;

    // power-on reset
    #1 rst = 1'b1;
    #2 chk_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // fill channel 0: count 1..8, afull from 6, full at 8, 9th push overflows
    for (int i = 1; i <= 9; i++) begin
      step(4'b0001, 4'b0000, 4'b0000, 4'b0000);
      c = (i > 8) ? 8 : i;
      expect_ch(0, c, c, (c == 8), 1'b0, (c >= 6), (c <= 2), (i == 9), 1'b0,
                (c == 8) ? 1 : 0, "fill0");
    end
    step(4'b0000, 4'b0000, 4'b0000, 4'b0001);
    expect_ch(0, 8, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, "ovf_clr0");

    // channel 1 up to 3, then drain past empty
    for (int i = 1; i <= 3; i++) begin
      step(4'b0010, 4'b0000, 4'b0000, 4'b0000);
      expect_ch(1, i, i, 1'b0, 1'b0, 1'b0, (i <= 2), 1'b0, 1'b0, 1, "up1");
    end
    for (int i = 1; i <= 4; i++) begin
      step(4'b0000, 4'b0010, 4'b0000, 4'b0000);
      c = (i >= 3) ? 0 : 3 - i;
      expect_ch(1, c, 3, 1'b0, (c == 0), 1'b0, 1'b1, 1'b0, (i == 4), 1, "drain1");
    end
    step(4'b0000, 4'b0010, 4'b0000, 4'b0010);
    expect_ch(1, 0, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, "udf_set_wins");
    step(4'b0000, 4'b0000, 4'b0000, 4'b0010);
    expect_ch(1, 0, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, "udf_clr1");

    // simultaneous push and pop at 0, 5 and DEPTH
    step(4'b1000, 4'b1000, 4'b0000, 4'b0000);
    expect_ch(3, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, "both_at0");
    for (int i = 1; i <= 5; i++) begin
      step(4'b1000, 4'b0000, 4'b0000, 4'b0000);
      expect_ch(3, i, i, 1'b0, 1'b0, 1'b0, (i <= 2), 1'b0, 1'b0, 1, "up3");
    end
    step(4'b1000, 4'b1000, 4'b0000, 4'b0000);
    expect_ch(3, 5, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "both_at5");
    step(4'b0001, 4'b0001, 4'b0000, 4'b0000);
    expect_ch(0, 8, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, "both_at8");

    // peak tracking and clear with a concurrent push on channel 2
    for (int i = 1; i <= 5; i++) begin
      step(4'b0100, 4'b0000, 4'b0000, 4'b0000);
      expect_ch(2, i, i, 1'b0, 1'b0, 1'b0, (i <= 2), 1'b0, 1'b0, 1, "up2");
    end
    for (int i = 1; i <= 3; i++) begin
      step(4'b0000, 4'b0100, 4'b0000, 4'b0000);
      expect_ch(2, 5 - i, 5, 1'b0, 1'b0, 1'b0, ((5 - i) <= 2), 1'b0, 1'b0, 1, "down2");
    end
    step(4'b0100, 4'b0000, 4'b0100, 4'b0000);
    expect_ch(2, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, "clr_up2");

    // set ovf on ch0 again, then reset asynchronously mid-cycle
    step(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    expect_ch(0, 8, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, "ovf_again");
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset("mid_rst");
    @(negedge clk);
    rst = 1'b0;

    // random traffic on all channels against the reference model
    for (int ch = 0; ch < NCH; ch++) begin
      m_cnt[ch] = 0; m_pk[ch] = 0; m_ovf[ch] = 1'b0; m_udf[ch] = 1'b0;
    end
    for (int n = 0; n < 1000; n++) begin
      ru = 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 15));
      for (int ch = 0; ch < NCH; ch++) begin
        rc[ch] = ($urandom_range(0, 29) == 0);
        re[ch] = ($urandom_range(0, 9) == 0);
      end
      step(ru, rd, rc, re);
      for (int ch = 0; ch < NCH; ch++) begin
        logic so, su;
        so = 1'b0; su = 1'b0;
        if (rc[ch]) begin
          m_cnt[ch] = 0; m_pk[ch] = 0; m_ovf[ch] = 1'b0; m_udf[ch] = 1'b0;
        end else begin
          if (ru[ch] && !rd[ch]) begin
            if (m_cnt[ch] == DEPTH) so = 1'b1;
            else m_cnt[ch] = m_cnt[ch] + 1;
          end else if (rd[ch] && !ru[ch]) begin
            if (m_cnt[ch] == 0) su = 1'b1;
            else m_cnt[ch] = m_cnt[ch] - 1;
          end
          m_ovf[ch] = so | (m_ovf[ch] & ~re[ch]);
          m_udf[ch] = su | (m_udf[ch] & ~re[ch]);
          if (m_cnt[ch] > m_pk[ch]) m_pk[ch] = m_cnt[ch];
        end
      end
      anyv = 0;
      for (int ch = 0; ch < NCH; ch++) if (m_cnt[ch] == DEPTH) anyv = 1;
      for (int ch = 0; ch < NCH; ch++) begin
        expect_ch(ch, m_cnt[ch], m_pk[ch], (m_cnt[ch] == DEPTH), (m_cnt[ch] == 0),
                  (m_cnt[ch] >= AFL), (m_cnt[ch] <= AEL), m_ovf[ch], m_udf[ch],
                  anyv, "rand");
      end
    end
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    repeat (3) @(posedge clk);
    #2;
    n_chk = n_chk + 1;
    if (q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
